// File: rtl/iram_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package iram_fetch_ctrl_pkg;

   typedef enum logic [1:0] {
      FS_IDLE  = 2'd0,
      FS_RUN   = 2'd1,
      FS_DRAIN = 2'd2
   } fetch_state_t;

   localparam int FETCH_Q_DEPTH = 2;
   localparam int FETCH_CNT_W   = $clog2(FETCH_Q_DEPTH + 1);
   localparam int FETCH_PTR_W   = $clog2(FETCH_Q_DEPTH);

endpackage

// File: rtl/iram_fetch_ctrl_if.sv
// Fetch control, instruction-RAM and decode-handshake signals of the fetch sequencer.
interface iram_fetch_ctrl_if #(
   parameter int N  = 32,
   parameter int AW = 9
);
   logic          Enable;
   logic          Redirect;
   logic [AW-1:0] RedirectPc;
   logic [AW-1:0] IramAddr;
   logic [N-1:0]  IramData;
   logic          InstrValid;
   logic          InstrReady;
   logic [N-1:0]  Instr;
   logic [AW-1:0] InstrPc;
   logic          Busy;

   modport master (
      input  Enable, Redirect, RedirectPc, IramData, InstrReady,
      output IramAddr, InstrValid, Instr, InstrPc, Busy
   );

   modport slave (
      output Enable, Redirect, RedirectPc, IramData, InstrReady,
      input  IramAddr, InstrValid, Instr, InstrPc, Busy
   );
endinterface

// File: rtl/iram_fetch_ctrl_skid_queue.sv
// fetch_skid_queue: 2-entry FIFO of {word, pc} between the RAM return path and decode.
module fetch_skid_queue
   import iram_fetch_ctrl_pkg::*;
#(
   parameter int N  = 32,
   parameter int AW = 9
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   push,
   input  logic [N-1:0]           push_word,
   input  logic [AW-1:0]          push_pc,
   input  logic                   pop,
   input  logic                   flush,
   output logic [FETCH_CNT_W-1:0] count,
   output logic                   head_valid,
   output logic [N-1:0]           head_word,
   output logic [AW-1:0]          head_pc
);

   logic [N-1:0]           word_q [FETCH_Q_DEPTH];
   logic [AW-1:0]          pc_q   [FETCH_Q_DEPTH];
   logic [FETCH_PTR_W-1:0] wr_ptr;
   logic [FETCH_PTR_W-1:0] rd_ptr;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FETCH_Q_DEPTH; i++) begin
            word_q[i] <= '0;
            pc_q[i]   <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            word_q[wr_ptr] <= push_word;
            pc_q[wr_ptr]   <= push_pc;
            wr_ptr         <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count + FETCH_CNT_W'(push) - FETCH_CNT_W'(pop);
      end
   end

   assign head_valid = (count != '0);
   assign head_word  = word_q[rd_ptr];
   assign head_pc    = pc_q[rd_ptr];

endmodule

// File: rtl/iram_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch pointer, issues RAM reads and queues returns for decode.
//   state    | meaning
//   FS_IDLE  | no fetching; waiting for Enable
//   FS_RUN   | issuing one read per cycle while the queue has room
//   FS_DRAIN | Enable dropped; the last outstanding return lands, then IDLE
module iram_fetch_ctrl
   import iram_fetch_ctrl_pkg::*;
#(
   parameter int N        = 32,
   parameter int K        = 512,
   parameter int RESET_PC = 0,
   localparam int AW      = $clog2(K)
) (
   input  logic              Clk,
   input  logic              Rst,
   iram_fetch_ctrl_if.master bus
);

   fetch_state_t           state;
   logic [AW-1:0]          fetch_pc;
   logic [AW-1:0]          fetch_pc_inc;
   logic [AW-1:0]          inflight_pc;
   logic                   inflight;
   logic                   issue;
   logic                   push;
   logic                   pop;
   logic                   q_valid;
   logic [FETCH_CNT_W-1:0] q_count;

   assign pop  = q_valid && bus.InstrReady;
   // A return landing in a redirect cycle belongs to the old stream.
   assign push = inflight && !bus.Redirect;

   // Room check counts the pending return, so a push can never find the queue full.
   assign issue = (state == FS_RUN) && !bus.Redirect &&
                  ((3'(q_count) + 3'(inflight)) <= (3'd1 + 3'(pop)));

   assign fetch_pc_inc = (fetch_pc == AW'(K - 1)) ? '0 : fetch_pc + 1'b1;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state       <= FS_IDLE;
         fetch_pc    <= AW'(RESET_PC);
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         if (bus.Redirect) begin
            fetch_pc <= bus.RedirectPc;
            inflight <= 1'b0;
         end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc_inc;
         end else begin
            inflight <= 1'b0;
         end

         case (state)
            FS_IDLE:  if (bus.Enable) state <= FS_RUN;
            FS_RUN:   if (!bus.Enable) state <= FS_DRAIN;
            // Nothing issues in DRAIN, so any outstanding return is pushed at this edge.
            FS_DRAIN: state <= bus.Enable ? FS_RUN : FS_IDLE;
            default:  state <= FS_IDLE;
         endcase
      end
   end

   fetch_skid_queue #(
      .N  (N),
      .AW (AW)
   ) u_queue (
      .Clk        (Clk),
      .Rst        (Rst),
      .push       (push),
      .push_word  (bus.IramData),
      .push_pc    (inflight_pc),
      .pop        (pop),
      .flush      (bus.Redirect),
      .count      (q_count),
      .head_valid (q_valid),
      .head_word  (bus.Instr),
      .head_pc    (bus.InstrPc)
   );

   assign bus.IramAddr   = fetch_pc;
   assign bus.InstrValid = q_valid;
   assign bus.Busy       = (state != FS_IDLE) || inflight;

endmodule
